// File: rtl/clock_pkg.sv
// Shared definitions for the clock digit stages (minute, hour, day).
// Ports: none (package); provides the active-low 7-segment glyph constants
//   used for the AM/PM indicator and any blanked digit.
package clock_pkg;

  // Active-low segment vector, bit order {g,f,e,d,c,b,a}.
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_A     = 7'b000_1000;
  localparam seg7_t SEG_P     = 7'b000_1100;

  // Selects the meridiem glyph for a 12 h display.
  function automatic seg7_t ampm_glyph(input logic is_pm);
    return is_pm ? SEG_P : SEG_A;
  endfunction

endpackage

// File: rtl/binary_to_bcd_8bit.sv
// Purely combinational binary to two-digit BCD converter (shift-add-3).
// Ports: bin   - 8-bit binary input, meaningful range 0..99
//        bcd   - tens digit in [7:4], units digit in [3:0]; the hundreds digit is discarded
module binary_to_bcd_8bit (
  input  logic [7:0] bin,
  output logic [7:0] bcd
);

  // {hundreds, tens, units, binary}
  logic [19:0] shreg;

  always_comb begin
    shreg = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      // Pre-correct any digit that would overflow past 9 after the doubling shift.
      if (shreg[11:8]  >= 4'd5) shreg[11:8]  = shreg[11:8]  + 4'd3;
      if (shreg[15:12] >= 4'd5) shreg[15:12] = shreg[15:12] + 4'd3;
      if (shreg[19:16] >= 4'd5) shreg[19:16] = shreg[19:16] + 4'd3;
      shreg = shreg << 1;
    end
    bcd = shreg[15:8];
  end

endmodule

// File: rtl/hour_counter_sync.sv
// Hour digit of the clock: counts 0..MODULO-1 on minute ticks, with set-mode up/down keys.
// Ports: clock/reset (async active-low); tick, set, key_up, key_down, mode inputs;
//   count_bin (binary hour), count_bcd (displayed hour, 24 h or 12 h), carry (wrap pulse
//   to the day stage), ampm_7seg (active-low AM/PM glyph, blank in 24 h mode).
// MODULO must be even and at most 100; BITS must be wide enough to hold MODULO-1.
module hour_counter_sync
  import clock_pkg::*;
#(
  parameter int MODULO = 24,
  parameter int BITS   = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tick,
  input  logic            set,
  input  logic            key_up,
  input  logic            key_down,
  input  logic            mode,
  output logic [BITS-1:0] count_bin,
  output logic [7:0]      count_bcd,
  output logic            carry,
  output logic [6:0]      ampm_7seg
);

  localparam logic [BITS-1:0] MAX  = BITS'(MODULO - 1);
  localparam logic [BITS-1:0] HALF = BITS'(MODULO / 2);
  localparam logic [BITS-1:0] ONE  = BITS'(1);

  logic [BITS-1:0] count_q, count_d;
  logic            carry_q, carry_d;
  logic            up_q, up_d;
  logic            dn_q, dn_d;
  logic [7:0]      bcd_q, bcd_d;
  seg7_t           seg_q, seg_d;

  logic            up_edge, dn_edge;
  logic [BITS-1:0] shown;

  // Key history resets to 1 so a key already held when reset releases is not a press.
  assign up_edge = key_up & ~up_q;
  assign dn_edge = key_down & ~dn_q;

  // Next count and wrap pulse. Comparisons happen before the arithmetic so the
  // count never leaves 0..MODULO-1, even transiently.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    up_d    = key_up;
    dn_d    = key_down;
    if (!set) begin
      if (tick) begin
        if (count_q == MAX) begin
          count_d = '0;
          carry_d = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end
    end else begin
      // Setting never signals the day stage, even when a key wraps the hour.
      if (up_edge && !dn_edge) begin
        count_d = (count_q == MAX) ? '0 : count_q + ONE;
      end else if (dn_edge && !up_edge) begin
        count_d = (count_q == '0) ? MAX : count_q - ONE;
      end
    end
  end

  // Display selection from the registered count; midnight and noon both show HALF in 12 h.
  always_comb begin
    shown = count_q;
    seg_d = SEG_BLANK;
    if (mode) begin
      if (count_q == '0 || count_q == HALF) begin
        shown = HALF;
      end else if (count_q < HALF) begin
        shown = count_q;
      end else begin
        shown = count_q - HALF;
      end
      seg_d = ampm_glyph(count_q >= HALF);
    end
  end

  binary_to_bcd_8bit u_bcd (
    .bin (8'(shown)),
    .bcd (bcd_d)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      carry_q <= 1'b0;
      up_q    <= 1'b1;
      dn_q    <= 1'b1;
      bcd_q   <= 8'h00;
      seg_q   <= SEG_BLANK;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      bcd_q   <= bcd_d;
      seg_q   <= seg_d;
    end
  end

  assign count_bin = count_q;
  assign carry     = carry_q;
  assign count_bcd = bcd_q;
  assign ampm_7seg = seg_q;

endmodule

// File: tb/tb_hour_counter_sync.sv
// Directed bench for hour_counter_sync (MODULO=24): run counting and wrap, 12 h display,
// set-mode keys, key held through reset, asynchronous reset during a carry.
module tb_hour_counter_sync;

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_A     = 7'b000_1000;
  localparam logic [6:0] G_P     = 7'b000_1100;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       set;
  logic       key_up;
  logic       key_down;
  logic       mode;
  logic [7:0] count_bin;
  logic [7:0] count_bcd;
  logic       carry;
  logic [6:0] ampm_7seg;

  int total;
  int bad;

  hour_counter_sync #(.MODULO(24), .BITS(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .set       (set),
    .key_up    (key_up),
    .key_down  (key_down),
    .mode      (mode),
    .count_bin (count_bin),
    .count_bcd (count_bcd),
    .carry     (carry),
    .ampm_7seg (ampm_7seg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Pulse tick for n consecutive cycles.
  task automatic advance(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    tick     = 1'b0;
    set      = 1'b0;
    key_up   = 1'b0;
    key_down = 1'b0;
    mode     = 1'b0;

    // Reset state
    step();
    chk("rst_bin",   32'(count_bin), 32'd0);
    chk("rst_carry", 32'(carry),     32'd0);
    chk("rst_bcd",   32'(count_bcd), 32'h00);
    chk("rst_seg",   32'(ampm_7seg), 32'(G_BLANK));
    reset = 1'b1;
    step();
    chk("idle_bin", 32'(count_bin), 32'd0);
    chk("idle_seg", 32'(ampm_7seg), 32'(G_BLANK));

    // 24 back-to-back ticks in 24 h mode: 1..23 then wrap to 0 with carry
    tick = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      chk($sformatf("run_bin%0d", i),   32'(count_bin), 32'(i % 24));
      chk($sformatf("run_carry%0d", i), 32'(carry),     32'(i == 24));
      chk($sformatf("run_bcd%0d", i),   32'(count_bcd), 32'(to_bcd(i - 1)));
    end
    tick = 1'b0;
    step();
    chk("post_wrap_carry", 32'(carry),     32'd0);
    chk("post_wrap_bin",   32'(count_bin), 32'd0);
    chk("post_wrap_bcd",   32'(count_bcd), 32'h00);

    // 12 h display sweep: H=0,11,12,13,23
    mode = 1'b1;
    step();
    chk("h0_bcd", 32'(count_bcd), 32'h12);
    chk("h0_seg", 32'(ampm_7seg), 32'(G_A));
    advance(11);
    step();
    chk("h11_bin", 32'(count_bin), 32'd11);
    chk("h11_bcd", 32'(count_bcd), 32'h11);
    chk("h11_seg", 32'(ampm_7seg), 32'(G_A));
    advance(1);
    step();
    chk("h12_bcd", 32'(count_bcd), 32'h12);
    chk("h12_seg", 32'(ampm_7seg), 32'(G_P));
    advance(1);
    step();
    chk("h13_bcd", 32'(count_bcd), 32'h01);
    chk("h13_seg", 32'(ampm_7seg), 32'(G_P));
    advance(10);
    step();
    chk("h23_bin", 32'(count_bin), 32'd23);
    chk("h23_bcd", 32'(count_bcd), 32'h11);
    chk("h23_seg", 32'(ampm_7seg), 32'(G_P));
    advance(1);
    chk("h23_wrap_carry", 32'(carry), 32'd1);
    step();

    // Set mode: down key from 0 wraps to 23 without carry
    set = 1'b1;
    step();
    chk("set_toggle_bin", 32'(count_bin), 32'd0);
    key_down = 1'b1;
    step();
    chk("dn_wrap_bin",   32'(count_bin), 32'd23);
    chk("dn_wrap_carry", 32'(carry),     32'd0);
    key_down = 1'b0;
    step();
    // Up key held 10 cycles: one step, 23 -> 0, no carry
    key_up = 1'b1;
    step();
    chk("up_wrap_bin",   32'(count_bin), 32'd0);
    chk("up_wrap_carry", 32'(carry),     32'd0);
    repeat (9) step();
    chk("up_held_bin", 32'(count_bin), 32'd0);
    key_up = 1'b0;
    step();

    // Both keys rise together with tick present: no change
    tick     = 1'b1;
    key_up   = 1'b1;
    key_down = 1'b1;
    step();
    chk("both_bin",   32'(count_bin), 32'd0);
    chk("both_carry", 32'(carry),     32'd0);
    step();
    chk("set_tick_bin", 32'(count_bin), 32'd0);
    tick     = 1'b0;
    key_up   = 1'b0;
    key_down = 1'b0;
    step();
    set = 1'b0;
    step();
    chk("unset_bin", 32'(count_bin), 32'd0);

    // Key held through reset release: no step; release then press steps once
    advance(5);
    chk("pre_rst_bin", 32'(count_bin), 32'd5);
    set    = 1'b1;
    key_up = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_bin", 32'(count_bin), 32'd0);
    step();
    reset = 1'b1;
    repeat (3) step();
    chk("held_through_rst_bin", 32'(count_bin), 32'd0);
    key_up = 1'b0;
    step();
    key_up = 1'b1;
    step();
    chk("press_after_rst_bin", 32'(count_bin), 32'd1);
    key_up = 1'b0;
    set    = 1'b0;
    step();

    // Reset while carry is high: immediate clear, no further carry
    advance(22);
    chk("pre_carry_bin", 32'(count_bin), 32'd23);
    tick = 1'b1;
    step();
    chk("carry_high", 32'(carry), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_carry_drop", 32'(carry),     32'd0);
    chk("rst_mid_bcd",    32'(count_bcd), 32'h00);
    chk("rst_mid_seg",    32'(ampm_7seg), 32'(G_BLANK));
    step();
    chk("rst_hold_carry", 32'(carry), 32'd0);
    tick  = 1'b0;
    reset = 1'b1;
    step();
    chk("rel_carry", 32'(carry),     32'd0);
    chk("rel_bin",   32'(count_bin), 32'd0);
    chk("rel_bcd",   32'(count_bcd), 32'h12);
    chk("rel_seg",   32'(ampm_7seg), 32'(G_A));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
